// File: rtl/tpu_host_pkg.sv
// Shared definitions for the TPU host loader.
//   state_t   : sequencer states IDLE -> LOAD -> FLUSH -> KICK -> WAIT -> DONE
//   depth_of  : RAM depth for a given address width
//   clamp_len : limits a requested word count to the RAM depth
package tpu_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_KICK  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/tpu_watchdog.sv
// Cycle watchdog for the WAIT phase of the host loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the counter
//   en         : count this cycle
//   expired    : high during the TIMEOUT_CYCLES-th enabled cycle since clr
module tpu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Counter holds at LAST so the flag stays up without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/tpu_host_loader.sv
// Hardware host sequencer for mini_tpu_top: streams words into TPU RAM from a
// base address (modulo DEPTH), pulses start, waits for done under a watchdog,
// captures the result and raises a one-cycle interrupt.
//   cmd_go / cmd_abort      : job start (IDLE only) / cancel (non-IDLE only)
//   cfg_base / cfg_len      : first RAM address / word count, latched on go
//   s_data/s_valid/s_ready  : input word stream
//   tpu_wr_addr/data/en     : RAM write port of mini_tpu_top
//   tpu_start / tpu_done    : start pulse out, done level in
//   tpu_result / result_out : raw result in, captured result out
//   result_valid, busy, irq, err_timeout, words_loaded : status
module tpu_host_loader
  import tpu_host_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned RESULT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_go,
  input  logic                    cmd_abort,
  input  logic [ADDR_WIDTH-1:0]   cfg_base,
  input  logic [ADDR_WIDTH:0]     cfg_len,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ADDR_WIDTH-1:0]   tpu_wr_addr,
  output logic [DATA_WIDTH-1:0]   tpu_wr_data,
  output logic                    tpu_wr_en,
  output logic                    tpu_start,
  input  logic                    tpu_done,
  input  logic [RESULT_WIDTH-1:0] tpu_result,
  output logic [RESULT_WIDTH-1:0] result_out,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    irq,
  output logic                    err_timeout,
  output logic [ADDR_WIDTH:0]     words_loaded
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned LW    = ADDR_WIDTH + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         accepted;
  logic                  done_q;
  logic                  done_rise;
  logic                  last_word;
  logic                  wd_expired;

  assign s_ready   = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  // Abort suppresses the pulses of the cycle it arrives in.
  assign tpu_start = (state == ST_KICK) && !cmd_abort;
  assign irq       = (state == ST_DONE) && !cmd_abort;
  // A done level left over from the previous job produces no edge here.
  assign done_rise = tpu_done && !done_q;
  assign last_word = ((accepted + LW'(1)) == len_q);

  tpu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ST_KICK),
    .en     (state == ST_WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      accepted     <= '0;
      done_q       <= 1'b0;
      tpu_wr_addr  <= '0;
      tpu_wr_data  <= '0;
      tpu_wr_en    <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      err_timeout  <= 1'b0;
      words_loaded <= '0;
    end else begin
      done_q    <= tpu_done;
      tpu_wr_en <= 1'b0;
      if ((state != ST_IDLE) && cmd_abort) begin
        state        <= ST_IDLE;
        result_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_go) begin
              base_q       <= cfg_base;
              len_q        <= LW'(clamp_len(32'(cfg_len), DEPTH));
              accepted     <= '0;
              words_loaded <= '0;
              result_valid <= 1'b0;
              err_timeout  <= 1'b0;
              state        <= (cfg_len == '0) ? ST_KICK : ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (s_valid && s_ready) begin
              tpu_wr_en    <= 1'b1;
              tpu_wr_addr  <= base_q + accepted[ADDR_WIDTH-1:0];
              tpu_wr_data  <= s_data;
              accepted     <= accepted + LW'(1);
              words_loaded <= words_loaded + LW'(1);
              if (last_word) state <= ST_FLUSH;
            end
          end
          ST_FLUSH: state <= ST_KICK;
          ST_KICK:  state <= ST_WAIT;
          ST_WAIT: begin
            if (done_rise) begin
              result_out   <= tpu_result;
              result_valid <= 1'b1;
              state        <= ST_DONE;
            end else if (wd_expired) begin
              err_timeout <= 1'b1;
              state       <= ST_DONE;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
